// File: rtl/img_mem_pkg.sv
// Shared constants, enums and address helpers for the image-memory data-side arbiter.
package img_mem_pkg;

  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned NUM_BANKS  = 5;
  localparam int unsigned BANK_SIZE  = 65536;
  localparam int unsigned BANK_OFS_W = $clog2(BANK_SIZE);
  localparam int unsigned BANK_IDX_W = ADDR_W - BANK_OFS_W;
  localparam int unsigned READ_LAT   = 2;
  localparam int unsigned CNT_W      = $clog2(READ_LAT + 1);

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_FILT = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RSP  = 2'd2
  } arb_state_e;

  // Only the populated banks are addressable; unpopulated bank indices are errors.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:BANK_OFS_W] < BANK_IDX_W'(NUM_BANKS);
  endfunction

endpackage

// File: rtl/img_mem_arbiter_rr.sv
// Two-input round-robin arbiter; remembers the last grantee and favours the other on a tie.
module rr_arbiter2
  import img_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_c_o
);

  req_id_e last_q;

  always_comb begin
    grant_c_o = 2'b00;
    if (en_i) begin
      case (valid_i)
        2'b01:   grant_c_o = 2'b01;
        2'b10:   grant_c_o = 2'b10;
        2'b11:   grant_c_o = (last_q == REQ_FILT) ? 2'b01 : 2'b10;
        default: grant_c_o = 2'b00;
      endcase
    end
  end

  // Reset to the filter so the CPU takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ_FILT;
    end else if (|grant_c_o) begin
      last_q <= req_id_e'(grant_c_o[1]);
    end
  end

endmodule

// File: rtl/img_mem_arbiter.sv
// Shares the image memory's data-side port between the CPU and the filter engine,
// sequencing reads across the memory latency and flagging out-of-range addresses.
module img_mem_arbiter
  import img_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [1:0]            rsp_err,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  req_id_e           gnt_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        rsp_valid_q;
  logic [1:0]        rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [1:0]        grant;
  logic              accept;
  req_id_e           win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_ok;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .en_i      (state_q == IDLE),
    .valid_i   (req_valid),
    .grant_c_o (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign win       = req_id_e'(grant[1]);
  assign sel_we    = win == REQ_FILT ? req_we[1] : req_we[0];
  assign sel_addr  = win == REQ_FILT ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign sel_wdata = win == REQ_FILT ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign sel_ok    = addr_in_range(sel_addr);

  // Sequencer: mem_addr is only updated on acceptance, so it stays put through the read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= REQ_CPU;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      mem_we_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            gnt_q <= win;
            if (!sel_ok) begin
              rsp_err_q[win] <= 1'b1;
              if (!sel_we) begin
                rsp_valid_q[win] <= 1'b1;
                rsp_data_q       <= '0;
              end
            end else if (sel_we) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
            end else begin
              mem_addr_q <= sel_addr;
              cnt_q      <= '0;
              state_q    <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == CNT_W'(READ_LAT - 1)) begin
            state_q <= RD_RSP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RD_RSP: begin
          rsp_data_q         <= mem_rdata;
          rsp_valid_q[gnt_q] <= 1'b1;
          state_q            <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Directed bench for img_mem_arbiter with a two-stage registered memory read model.
module tb_img_mem_arbiter;
  import img_mem_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic [1:0]          rsp_err;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic [DATA_W-1:0]   mem_s1;

  int checks = 0;
  int errors = 0;
  int n_cpu  = 0;
  int n_filt = 0;

  img_mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Read data is a fixed function of the address, two registered stages behind mem_addr.
  function automatic logic [7:0] mem_model(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'hC2;
  endfunction

  always @(posedge clk) begin
    mem_s1    <= mem_model(mem_addr);
    mem_rdata <= mem_s1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [7:0] d);
    req_we[id]                   = we;
    req_addr[id*ADDR_W +: ADDR_W] = a;
    req_wdata[id*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    nxt(); nxt();
    reset = 1'b0;

    // Reset state
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    #1 chk("rst_ready_none", 32'(req_ready), 32'h0);
    req_valid = 2'b11;
    #1 chk("rst_first_tie_cpu", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    nxt();

    // CPU write 0x5A to 0x10003
    set_req(0, 1'b1, 19'h10003, 8'h5A);
    req_valid = 2'b01;
    #1 chk("wr_ready", 32'(req_ready), 32'h1);
    nxt();
    req_valid = 2'b00;
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h10003);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h5A);
    req_valid = 2'b01;
    #1 chk("wr_ready_again", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    nxt();
    chk("wr_mem_we_one_cycle", 32'(mem_we), 32'h0);

    // Filter read 0x40001
    set_req(1, 1'b0, 19'h40001, 8'h00);
    req_valid = 2'b10;
    #1 chk("rd_ready", 32'(req_ready), 32'h2);
    for (int c = 1; c <= 3; c++) begin
      nxt();
      req_valid = 2'b00;
      chk($sformatf("rd_addr_c%0d", c), 32'(mem_addr), 32'h40001);
      chk($sformatf("rd_no_rsp_c%0d", c), 32'(rsp_valid), 32'h0);
      chk($sformatf("rd_no_we_c%0d", c), 32'(mem_we), 32'h0);
    end
    nxt();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("rd_rsp_data", 32'(rsp_data), 32'hC3);
    nxt();
    chk("rd_rsp_one_cycle", 32'(rsp_valid), 32'h0);

    // Continuous writes from both requesters: strict alternation starting with the CPU
    set_req(0, 1'b1, 19'h00100, 8'h11);
    set_req(1, 1'b1, 19'h20200, 8'h22);
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("alt_ready_k%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("alt_not_both_k%0d", k), 32'(&req_ready), 32'h0);
      if (req_ready == 2'b01) n_cpu++;
      if (req_ready == 2'b10) n_filt++;
      nxt();
      chk($sformatf("alt_we_k%0d", k), 32'(mem_we), 32'h1);
      chk($sformatf("alt_addr_k%0d", k), 32'(mem_addr), (k % 2 == 0) ? 32'h00100 : 32'h20200);
    end
    req_valid = 2'b00;
    chk("alt_cpu_grants", 32'(n_cpu), 32'd4);
    chk("alt_filt_grants", 32'(n_filt), 32'd4);
    nxt();

    // CPU read of unpopulated bank 5
    set_req(0, 1'b0, 19'h50000, 8'h00);
    req_valid = 2'b01;
    #1 chk("oor_rd_ready", 32'(req_ready), 32'h1);
    nxt();
    req_valid = 2'b00;
    chk("oor_rd_valid", 32'(rsp_valid), 32'h1);
    chk("oor_rd_err", 32'(rsp_err), 32'h1);
    chk("oor_rd_data", 32'(rsp_data), 32'h0);
    chk("oor_rd_no_we", 32'(mem_we), 32'h0);
    nxt();
    chk("oor_rd_no_we2", 32'(mem_we), 32'h0);
    chk("oor_rd_err_cleared", 32'(rsp_err), 32'h0);

    // CPU write to unpopulated bank 6
    set_req(0, 1'b1, 19'h60000, 8'hAA);
    req_valid = 2'b01;
    nxt();
    req_valid = 2'b00;
    chk("oor_wr_err", 32'(rsp_err), 32'h1);
    chk("oor_wr_no_valid", 32'(rsp_valid), 32'h0);
    chk("oor_wr_no_we", 32'(mem_we), 32'h0);
    nxt();

    // Reset during a CPU read
    set_req(0, 1'b0, 19'h00007, 8'h00);
    req_valid = 2'b01;
    nxt();
    req_valid = 2'b00;
    chk("abort_addr_c1", 32'(mem_addr), 32'h00007);
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    chk("abort_mem_we", 32'(mem_we), 32'h0);
    chk("abort_mem_addr", 32'(mem_addr), 32'h0);
    req_valid = 2'b11;
    #1 chk("abort_tie_cpu", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("abort_no_rsp_%0d", c), 32'(rsp_valid), 32'h0);
      nxt();
    end

    // Filter waits behind a CPU read
    set_req(0, 1'b0, 19'h30005, 8'h00);
    set_req(1, 1'b0, 19'h00022, 8'h00);
    req_valid = 2'b01;
    #1 chk("blk_cpu_ready", 32'(req_ready), 32'h1);
    for (int c = 1; c <= 3; c++) begin
      nxt();
      req_valid = 2'b10;
      #1 chk($sformatf("blk_filt_wait_c%0d", c), 32'(req_ready), 32'h0);
    end
    nxt();
    chk("blk_cpu_rsp", 32'(rsp_valid), 32'h1);
    chk("blk_cpu_data", 32'(rsp_data), 32'hC7);
    #1 chk("blk_filt_ready_c4", 32'(req_ready), 32'h2);
    nxt();
    req_valid = 2'b00;
    chk("blk_filt_addr", 32'(mem_addr), 32'h00022);
    nxt(); nxt(); nxt();
    chk("blk_filt_rsp", 32'(rsp_valid), 32'h2);
    chk("blk_filt_data", 32'(rsp_data), 32'hE0);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
